// File: rtl/fib_capture_pkg.sv
`default_nettype none
// ==== fib_capture_pkg : register map, field positions and bus states for fib_capture ====
// ==== rev 1.0 ====
package fib_capture_pkg;

  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_WRAP_BIT  = 3;
  localparam int STAT_CNT_LSB   = 8;
  localparam int CNT_W          = 5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_THR_LSB   = 8;
  localparam int THR_W          = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic ovf, input logic wrap,
                                              input logic [CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_FULL_BIT]  = full;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_WRAP_BIT]  = wrap;
    s[STAT_CNT_LSB +: CNT_W] = cnt;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_capture_if.sv
`default_nettype none
// ==== fib_capture_if : Wishbone classic slave bundle for fib_capture ====
// ==== rev 1.0 ====
interface fib_capture_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/fib_fifo.sv
`default_nettype none
// ==== fib_fifo : synchronous FIFO with push/pop/flush and occupancy count ====
// ==== rev 1.0 ====
module fib_fifo
  import fib_capture_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  // A pop frees the head slot this cycle, so a push into a full FIFO is still accepted.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/fib_capture.sv
`default_nettype none
// ==== fib_capture : Fibonacci term capture FIFO with Wishbone drain, sticky flags and fill irq ====
// ==== rev 1.0 ====
module fib_capture
  import fib_capture_pkg::*;
#(
  parameter int          WIDTH     = 30,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0100
) (
  input  logic             clk,
  input  logic             reset,
  fib_capture_if.slave     wb,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             irq_out
);

  bus_state_e       state_q;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic             en_q, en_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic             ovf_q, ovf_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             irq_q, irq_d;

  logic             hit, rd, wr, pop, flush, cap, push;
  logic [7:0]       off;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] head;
  logic             full, empty;
  logic [CNT_W-1:0] count;
  logic             unused_dat;

  assign unused_dat = ^{wb.wbs_dat_i[31:13], wb.wbs_dat_i[7:4]};

  assign hit   = (wb.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign off   = wb.wbs_adr_i[7:0];
  assign rd    = (state_q == ST_ACK) && !wb.wbs_we_i && hit;
  assign wr    = (state_q == ST_ACK) && wb.wbs_we_i && hit && (|wb.wbs_sel_i);
  assign pop   = rd && (off == OFF_DATA) && !empty;
  assign flush = wr && (off == OFF_CTRL) && wb.wbs_dat_i[CTRL_FLUSH_BIT];
  assign cap   = in_valid && en_q;
  assign push  = cap && !flush;

  fib_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (in_value),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFF_DATA:   rdata = empty ? 32'h0 : 32'(head);
        OFF_STATUS: rdata = pack_status(empty, full, ovf_q, wrap_q, count);
        OFF_CTRL: begin
          rdata[CTRL_EN_BIT] = en_q;
          rdata[CTRL_THR_LSB +: THR_W] = thr_q;
        end
        default:    rdata = '0;
      endcase
    end
  end

  // Flag sets are applied after write-1-to-clear so a same-cycle event is not lost.
  always_comb begin
    en_d   = en_q;
    thr_d  = thr_q;
    ovf_d  = ovf_q;
    wrap_d = wrap_q;
    last_d = last_q;
    if (wr && off == OFF_STATUS) begin
      if (wb.wbs_dat_i[STAT_OVF_BIT])  ovf_d  = 1'b0;
      if (wb.wbs_dat_i[STAT_WRAP_BIT]) wrap_d = 1'b0;
    end
    if (wr && off == OFF_CTRL) begin
      en_d  = wb.wbs_dat_i[CTRL_EN_BIT];
      thr_d = wb.wbs_dat_i[CTRL_THR_LSB +: THR_W];
    end
    if (cap && full && !pop && !flush) ovf_d = 1'b1;
    if (cap && (in_value < last_q))     wrap_d = 1'b1;
    if (cap)                            last_d = in_value;
    irq_d = en_q && (thr_q != '0) && (count >= thr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      thr_q  <= '0;
      ovf_q  <= 1'b0;
      wrap_q <= 1'b0;
      last_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      thr_q  <= thr_d;
      ovf_q  <= ovf_d;
      wrap_q <= wrap_d;
      last_q <= last_d;
      irq_q  <= irq_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          dat_q <= '0;
          if (wb.wbs_stb_i && wb.wbs_cyc_i) state_q <= ST_ACK;
        end
        ST_ACK: begin
          ack_q   <= 1'b1;
          dat_q   <= rdata;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign irq_out      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_capture.sv
`default_nettype none
// ==== tb_fib_capture : table-driven and scoreboarded bench for fib_capture ====
// ==== rev 1.0 ====
module tb_fib_capture;

  localparam int          WIDTH = 30;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_DATA   = 32'h3000_0100;
  localparam logic [31:0] A_STATUS = 32'h3000_0104;
  localparam logic [31:0] A_CTRL   = 32'h3000_0108;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_value;
  logic             irq_out;

  fib_capture_if bus ();

  fib_capture #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BASE (32'h3000_0100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (bus),
    .in_valid (in_valid),
    .in_value (in_value),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    bit          accept;
    logic [31:0] exp_status;
  } strobe_vec_t;

  strobe_vec_t tbl[15];
  logic [31:0] sb[$];
  int          n_cmp;
  int          n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One classic cycle; optionally lands an in_valid strobe on the ack edge.
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                         input bit coinc, input logic [31:0] cval, output logic [31:0] rdat);
    bit got;
    int lat;
    got = 1'b0;
    lat = -1;
    rdat = '0;
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (coinc) begin
        in_valid = (n == 0);
        in_value = cval[WIDTH-1:0];
      end
      if (bus.wbs_ack_o) begin
        got  = 1'b1;
        lat  = n;
        rdat = bus.wbs_dat_o;
      end
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    in_valid      = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: no ack for adr 0x%08h within 8 cycles", adr);
    end else begin
      check("ack_latency", 32'(lat), 32'd1);
    end
  endtask

  task automatic wr_reg(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, 1'b0, 32'h0, dummy);
  endtask

  task automatic chk_reg(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, adr, 32'h0, 1'b0, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic read_data(input string name);
    logic [31:0] r;
    logic [31:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    wb_xfer(1'b0, A_DATA, 32'h0, 1'b0, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic strobe(input logic [31:0] v, input bit accept);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = v[WIDTH-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (accept) sb.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      strobe(tbl[i].value, tbl[i].accept);
      chk_reg($sformatf("status_row%0d", i), A_STATUS, tbl[i].exp_status);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    n_cmp = 0;
    n_err = 0;

    // value, accepted, STATUS after the strobe
    tbl[0]  = '{32'd1,  1'b1, 32'h0000_0100};
    tbl[1]  = '{32'd1,  1'b1, 32'h0000_0200};
    tbl[2]  = '{32'd2,  1'b1, 32'h0000_0300};
    tbl[3]  = '{32'd3,  1'b1, 32'h0000_0400};
    tbl[4]  = '{32'd5,  1'b1, 32'h0000_0500};
    tbl[5]  = '{32'd10, 1'b1, 32'h0000_0100};
    tbl[6]  = '{32'd11, 1'b1, 32'h0000_0200};
    tbl[7]  = '{32'd12, 1'b1, 32'h0000_0300};
    tbl[8]  = '{32'd13, 1'b1, 32'h0000_0400};
    tbl[9]  = '{32'd14, 1'b1, 32'h0000_0500};
    tbl[10] = '{32'd15, 1'b1, 32'h0000_0600};
    tbl[11] = '{32'd16, 1'b1, 32'h0000_0700};
    tbl[12] = '{32'd17, 1'b1, 32'h0000_0802};
    tbl[13] = '{32'd18, 1'b0, 32'h0000_0806};
    tbl[14] = '{32'd19, 1'b0, 32'h0000_0806};

    reset = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("reset_dat", bus.wbs_dat_o, 32'h0);
    check("reset_irq", {31'b0, irq_out}, 32'h0);
    reset = 1'b0;
    chk_reg("reset_status", A_STATUS, 32'h0000_0001);
    chk_reg("reset_ctrl", A_CTRL, 32'h0);

    // Basic capture and drain
    wr_reg(A_CTRL, 32'h0000_0001);
    chk_reg("ctrl_enable", A_CTRL, 32'h0000_0001);
    run_rows(0, 4);
    for (int i = 0; i < 5; i++) read_data($sformatf("drain_basic%0d", i));
    read_data("read_empty");
    chk_reg("status_after_drain", A_STATUS, 32'h0000_0001);

    // Overflow: 10 strobes into 8 entries
    run_rows(5, 14);
    for (int i = 0; i < 8; i++) read_data($sformatf("drain_full%0d", i));
    chk_reg("status_ovf_sticky", A_STATUS, 32'h0000_0005);
    wr_reg(A_STATUS, 32'h0000_0004);
    chk_reg("status_ovf_cleared", A_STATUS, 32'h0000_0001);

    // Wrap detection
    strobe(32'h3FFF_FFF0, 1'b1);
    strobe(32'h0000_0005, 1'b1);
    chk_reg("status_wrapped", A_STATUS, 32'h0000_0208);
    wr_reg(A_STATUS, 32'h0000_0008);
    chk_reg("status_wrap_cleared", A_STATUS, 32'h0000_0200);
    read_data("drain_wrap0");
    read_data("drain_wrap1");

    // Threshold interrupt with one cycle of lag
    wr_reg(A_CTRL, 32'h0000_0401);
    check("irq_idle", {31'b0, irq_out}, 32'h0);
    strobe(32'd6, 1'b1);
    strobe(32'd7, 1'b1);
    strobe(32'd8, 1'b1);
    check("irq_count3", {31'b0, irq_out}, 32'h0);
    strobe(32'd9, 1'b1);
    check("irq_lag", {31'b0, irq_out}, 32'h0);
    @(posedge clk); #1;
    check("irq_rise", {31'b0, irq_out}, 32'h1);
    read_data("irq_pop");
    check("irq_hold_at_ack", {31'b0, irq_out}, 32'h1);
    @(posedge clk); #1;
    check("irq_fall", {31'b0, irq_out}, 32'h0);
    for (int i = 0; i < 3; i++) read_data($sformatf("drain_irq%0d", i));

    // Threshold above DEPTH never fires; then push and pop on the same edge while full
    wr_reg(A_CTRL, 32'h0000_0901);
    for (int i = 0; i < 8; i++) strobe(32'd100 + 32'(i), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("irq_thr_gt_depth", {31'b0, irq_out}, 32'h0);
    chk_reg("status_full_no_ovf", A_STATUS, 32'h0000_0802);
    wb_xfer(1'b0, A_DATA, 32'h0, 1'b1, 32'd108, r);
    check("coinc_pop", r, sb.pop_front());
    sb.push_back(32'd108);
    chk_reg("status_coinc", A_STATUS, 32'h0000_0802);
    for (int i = 0; i < 8; i++) read_data($sformatf("drain_coinc%0d", i));

    // Flush with a strobe on the same edge
    wr_reg(A_CTRL, 32'h0000_0001);
    for (int i = 0; i < 6; i++) strobe(32'd200 + 32'(i), 1'b1);
    chk_reg("status_pre_flush", A_STATUS, 32'h0000_0600);
    wb_xfer(1'b1, A_CTRL, 32'h0000_0003, 1'b1, 32'd206, r);
    sb.delete();
    chk_reg("status_flushed", A_STATUS, 32'h0000_0001);
    chk_reg("ctrl_after_flush", A_CTRL, 32'h0000_0001);
    wr_reg(A_CTRL, 32'h0);
    strobe(32'd300, 1'b0);
    chk_reg("status_disabled", A_STATUS, 32'h0000_0001);
    read_data("read_empty_end");

    // Unmapped offset and foreign base read back zero
    chk_reg("unmapped_offset", 32'h3000_010C, 32'h0);
    chk_reg("foreign_base", 32'h3000_0204, 32'h0);

    // Reset while ack is high drops it immediately
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = A_STATUS;
    repeat (2) @(posedge clk);
    #1;
    check("ack_before_reset", {31'b0, bus.wbs_ack_o}, 32'h1);
    check("dat_before_reset", bus.wbs_dat_o, 32'h0000_0001);
    reset = 1'b1;
    #1;
    check("ack_async_reset", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("dat_async_reset", bus.wbs_dat_o, 32'h0);
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reg("status_post_reset", A_STATUS, 32'h0000_0001);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fib_capture.md
# fib_capture

Downstream capture stage for the Fibonacci generator's output word. It accepts each new value on a single-cycle strobe and buffers it in a small FIFO. The FIFO is drained by the Caravel management core over Wishbone. The block flags overflow and counter wrap-around, and raises an interrupt once a programmable fill level is reached. It sits beside the Wishbone logic inside the Fibonacci wrapper, on the `wb_clk_i` domain.

## Interface
- `WIDTH`, 30: captured value width (1–32).
- `DEPTH`, 8: FIFO entries; power of two, 2–16.
- `ADDR_BASE`, 32'h3000_0100: register base; `wbs_adr_i[31:8]` must match `ADDR_BASE[31:8]`.
- `clk`  in  1  single clock; the wrapper drives it from `wb_clk_i`.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  one-cycle strobe, synchronous to `clk`: `in_value` is a new Fibonacci term.
- `in_value`  in  WIDTH  term to capture.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic slave controls.
- `wbs_sel_i`  in  4  byte selects; `4'b0000` suppresses a write, any other value writes the full word.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data; valid only while `wbs_ack_o` is high, 0 otherwise.
- `irq_out`  out  1  level interrupt.

## Operation

**Registers** (word offsets)
- 0x00 DATA (RO): reading pops the FIFO head, zero-extended. Reading while empty returns 0 with no state change.
- 0x04 STATUS:
  - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 wrapped (sticky), bits[12:8] count.
  - Writing 1 to bit2 or bit3 clears that bit; other bits ignore writes.
- 0x08 CTRL (RW, reset 0):
  - bit0 enable.
  - bit1 flush: self-clearing, reads 0.
  - bits[12:8] threshold.
- Unmapped offsets and non-matching bases: ack, read 0, writes ignored.

**Capture**
- Applies only when `in_valid` is high and enable is 1.
- Not full: push `in_value`.
- Full: drop the value and set overflow.
- `in_value < last_value`: set wrapped (unsigned compare).
- `last_value` (reset 0) updates on every enabled `in_valid`, including dropped ones.
- While disabled, `in_valid` is ignored entirely.

**FIFO and interrupt**
- Simultaneous push and pop: both happen and count is unchanged. If full, the push is accepted because a slot frees in the same cycle; no overflow.
- Flush: count goes to 0 and pointers reset. A push in the same cycle is discarded. Sticky flags are kept.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- `irq_out` = enable && threshold != 0 && count >= threshold.
- Threshold > DEPTH: `irq_out` never asserts.

**Bus state machine**
- IDLE: on `stb && cyc`, go to ACK.
- ACK: `wbs_ack_o` = 1 for one cycle, perform the read/pop or the write, return to IDLE.
- A held request is therefore acked every second cycle.

## Timing
- Reset values: `wbs_ack_o` 0, `wbs_dat_o` 0, `irq_out` 0, CTRL 0, count 0, flags 0, `last_value` 0.
- Read/write latency: request sampled at edge N, ack and data registered at edge N+1.
- Pop and register writes take effect at the ack edge. The effect is visible in STATUS on the next access.
- Push: `in_valid` at edge N, count increments at edge N+1.
- `irq_out` is registered and follows count and CTRL with one cycle of lag.
- `reset` mid-transaction: ack drops immediately (async) and the transaction is lost. The master must retry.

## Structure
- Shared package `fib_capture_pkg`:
  - register offsets (DATA, STATUS, CTRL);
  - STATUS/CTRL bit positions and field widths;
  - bus state enum {IDLE, ACK}.
- Sub-module `fib_fifo`: synchronous FIFO with push, pop, flush, full, empty, count; parameterised WIDTH/DEPTH. The register and bus logic stays in `fib_capture`.

## Test plan
- Reset, CTRL=0x0000_0001, strobe 1,1,2,3,5 → STATUS count=5; five DATA reads return 1,1,2,3,5; sixth read returns 0; empty=1.
- DEPTH=8, strobe 10 values with no reads → full=1, overflow=1, count=8. DATA returns the first 8 values. Writing 0x4 to STATUS clears overflow.
- Strobe 0x3FFF_FFF0 then 0x0000_0005 → wrapped=1. Writing 0x8 clears it.
- CTRL threshold=4, enable=1: after the 4th push, `irq_out` rises one cycle later. One DATA read (count 3) → `irq_out` falls.
- Full FIFO with an `in_valid` landing on the ack edge of a DATA read → count stays 8, overflow stays 0, and the new value is last out.
- CTRL write with flush=1 while count=6 and a simultaneous `in_valid` → count=0 and empty=1 next cycle; enable unchanged; `in_valid` with CTRL=0 leaves count=0.
